tx_engine: RTL
==============

// Module: tx_engine
// PURPOSE
//  64-bit PCIe transaction-layer transmit unit; the downstream partner of the receive engine.
//  Builds 1-DW CplD TLPs answering host register/user reads, using the request fields latched by the receive engine.
//  Also issues 32-bit MRd TLPs for DMA reads; the returning CplD data is consumed by the receive engine.
//  Output drives the PCIe core AXI-S TX port.
// PARAMETERS
//  C_DATA_WIDTH  64    TX AXI-S data width (only 64 supported)
//  NUM_TAGS      32    DMA read tags issued; tag counter wraps at NUM_TAGS-1 -> 0
// PORTS
//  clk_i            in   1   250 MHz core clock
//  rst_n            in   1   async active-low reset
//  s_axis_tx_tdata  out  64  TLP data: DW(n) in [31:0], DW(n+1) in [63:32]
//  s_axis_tx_tkeep  out  8   byte enables
//  s_axis_tx_tlast  out  1   last beat of TLP
//  s_axis_tx_tvalid out  1   beat valid
//  s_axis_tx_tready in   1   core accepts beat
//  completer_id_i   in   16  {bus,dev,func} from core cfg
//  req_compl_wd_i   in   1   completion request, level; held until compl_done_o
//  compl_done_o     out  1   1-cycle pulse: CplD last beat accepted
//  tx_reg_data_i    in   32  completion payload
//  req_tc_i/td_i/ep_i/attr_i  in  3/1/1/2  echoed request fields
//  req_len_i        in   10  request length (echoed; CplD always 1 DW)
//  req_rid_i        in   16  requester ID
//  req_tag_i        in   8   request tag
//  req_addr_i       in   7   lower address
//  dma_rd_req_i     in   1   DMA read request, level
//  dma_rd_addr_i    in   32  DW-aligned host address
//  dma_rd_len_i     in   10  length in DW (0 = 1024)
//  dma_rd_ack_o     out  1   1-cycle pulse: MRd last beat accepted
//  dma_rd_tag_o     out  8   tag used by the MRd; valid with dma_rd_ack_o
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FSM in IDLE; tag counter 0; cpl_armed=1.
//  FSM: IDLE, CPL_HDR, CPL_DATA, MRD_HDR, MRD_ADDR.
//  IDLE:
//   - tvalid=0.
//   - if req_compl_wd_i & cpl_armed -> CPL_HDR;
//   - else if dma_rd_req_i -> MRD_HDR.
//   - Completion has strict priority when both are requested in the same cycle.
//   - All request inputs are sampled into registers on this transition.
//  CPL_HDR (beat 0):
//   - tdata[31:0] = {1'b0,2'b10,5'b01010,1'b0,tc,4'b0,td,ep,attr,2'b0,10'd1};
//   - tdata[63:32] = {completer_id,3'b000,1'b0,12'd4};
//   - tkeep=FF, tlast=0.
//  CPL_DATA (beat 1):
//   - tdata = {tx_reg_data,req_rid,req_tag,1'b0,req_addr}; tkeep=FF, tlast=1.
//   - on accept: compl_done_o=1 next cycle, cpl_armed<=0, -> IDLE.
//  cpl_armed:
//   - set again only when req_compl_wd_i is sampled low.
//   - the receive engine drops the request one cycle after compl_done_o, so this blocks a duplicate CplD.
//  MRD_HDR (beat 0):
//   - tdata[31:0] = {1'b0,2'b00,5'b00000,1'b0,3'b0,4'b0,1'b0,1'b0,2'b00,2'b0,len};
//   - tdata[63:32] = {completer_id,tag,4'hF,first_be}; tkeep=FF, tlast=0.
//   - last BE = 4'h0 when len==1, else 4'hF; first_be = 4'hF.
//  MRD_ADDR (beat 1):
//   - tdata = {32'h0,addr[31:2],2'b00}; tkeep=0F, tlast=1.
//   - on accept: dma_rd_ack_o pulse with dma_rd_tag_o=tag; tag<=tag+1 (wrap); -> IDLE.
//  Handshake:
//   - a beat advances only on tvalid&tready.
//   - with tready low, tdata/tkeep/tlast/tvalid are held stable, with no bubbles between the 2 beats.
//   - tvalid is registered: beat 0 is presented the cycle after leaving IDLE.
//  Latency: request high -> first tvalid = 2 cycles; back-to-back TLPs need >=1 IDLE cycle between them.
//  Inputs changing mid-TLP have no effect (registered copies are used).
//  Reset mid-TLP:
//   - tvalid drops immediately (async); no done/ack pulse is issued.
//   - the core discards the partial TLP.
// TESTING
//  1. req_compl_wd=1, data=DEADBEEF, rid=0100, tag=07, addr=0x10, cid=0200, tready=1
//     -> beat0 {02000004,4A000001}, beat1 {DEADBEEF,01000710} tlast=1, compl_done 1 pulse.
//  2. Same as 1 with req held 1 cycle after compl_done -> exactly one CplD emitted.
//  3. dma_rd_req, addr=0x8000_0040, len=32 -> beat0[31:0]=00000020, [63:32]={0200,00,FF},
//     beat1=0000000080000040 tkeep=0F, ack with tag 0.
//  4. tready toggled 1/0 every cycle during 1 and 3 -> identical beats, held stable while stalled.
//  5. compl and dma requests asserted in the same cycle -> CplD first, then MRd.
//  6. 33 MRds -> tags 0..31 then 0; rst_n low during beat0 -> all outputs 0 at once, FSM IDLE.

Source files
------------

// File: rtl/tx_engine.sv
// PCIe TX engine: 2-beat 1-DW CplD for register reads and 2-beat 32-bit MRd for DMA reads on a 64-bit AXI-S TX port.
// Latency: request high -> beat 0 valid after 2 clocks; done/ack pulse the cycle after the last beat is accepted.
// Backpressure: beats advance only on tvalid&tready; stalled beats hold data/keep/last/valid stable, no inter-beat bubble.
module tx_engine #(
  parameter int C_DATA_WIDTH = 64,
  parameter int NUM_TAGS     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  // AXI-S TX toward the PCIe core
  output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
  output logic [C_DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
  output logic                      s_axis_tx_tlast,
  output logic                      s_axis_tx_tvalid,
  input  logic                      s_axis_tx_tready,
  // Configuration
  input  logic [15:0]               completer_id_i,
  // Completion request from the receive engine
  input  logic                      req_compl_wd_i,
  output logic                      compl_done_o,
  input  logic [31:0]               tx_reg_data_i,
  input  logic [2:0]                req_tc_i,
  input  logic                      req_td_i,
  input  logic                      req_ep_i,
  input  logic [1:0]                req_attr_i,
  input  logic [9:0]                req_len_i,
  input  logic [15:0]               req_rid_i,
  input  logic [7:0]                req_tag_i,
  input  logic [6:0]                req_addr_i,
  // DMA read request
  input  logic                      dma_rd_req_i,
  input  logic [31:0]               dma_rd_addr_i,
  input  logic [9:0]                dma_rd_len_i,
  output logic                      dma_rd_ack_o,
  output logic [7:0]                dma_rd_tag_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CPL_HDR  = 3'd1;
  localparam logic [2:0] S_CPL_DATA = 3'd2;
  localparam logic [2:0] S_MRD_HDR  = 3'd3;
  localparam logic [2:0] S_MRD_ADDR = 3'd4;

  localparam logic [7:0] TAG_MAX = 8'(NUM_TAGS - 1);

  // FSM and bookkeeping
  logic [2:0]  state_q, state_d;
  logic [7:0]  tag_q, tag_d;
  logic        cpl_armed_q, cpl_armed_d;

  // Registered AXI-S outputs and status pulses
  logic [C_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [C_DATA_WIDTH/8-1:0] tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic [7:0]  ack_tag_q, ack_tag_d;

  // Request fields captured when leaving IDLE, so mid-TLP input changes are ignored
  logic        cap_cpl, cap_mrd;
  logic [15:0] cid_q;
  logic [2:0]  tc_q;
  logic        td_q;
  logic        ep_q;
  logic [1:0]  attr_q;
  logic [15:0] rid_q;
  logic [7:0]  rtag_q;
  logic [6:0]  raddr_q;
  logic [31:0] rdata_q;
  logic [29:0] mrd_addr_q;
  logic [9:0]  mrd_len_q;

  logic        beat_fire;
  logic [3:0]  mrd_last_be;
  logic [63:0] cpl_beat0, cpl_beat1, mrd_beat0, mrd_beat1;

  // A CplD here always carries exactly one DW, and DMA addresses are DW aligned,
  // so the echoed length and the two low address bits carry no information.
  logic unused_ok;
  assign unused_ok = ^{req_len_i, dma_rd_addr_i[1:0]};

  assign beat_fire = tvalid_q & s_axis_tx_tready;

  // A single-DW read must not enable any bytes of a (non-existent) last DW.
  assign mrd_last_be = (mrd_len_q == 10'd1) ? 4'h0 : 4'hF;

  // CplD header: DW1 = {completer, status/BCM, byte count 4}; DW0 = fmt/type 3DW+data, length 1.
  assign cpl_beat0 = {cid_q, 3'b000, 1'b0, 12'd4,
                      1'b0, 2'b10, 5'b01010, 1'b0, tc_q, 4'b0,
                      td_q, ep_q, attr_q, 2'b0, 10'd1};
  // CplD tail: DW3 = payload, DW2 = {requester, tag, lower address}.
  assign cpl_beat1 = {rdata_q, rid_q, rtag_q, 1'b0, raddr_q};
  // MRd32 header: DW1 = {requester (us), tag, last BE, first BE}; DW0 = length only.
  assign mrd_beat0 = {cid_q, tag_q, mrd_last_be, 4'hF,
                      1'b0, 2'b00, 5'b00000, 1'b0, 3'b0, 4'b0,
                      1'b0, 1'b0, 2'b00, 2'b0, mrd_len_q};
  // MRd32 address DW; upper DW lane is unused and masked by tkeep.
  assign mrd_beat1 = {32'h0, mrd_addr_q, 2'b00};

  // Next-state logic: FSM, output beat registers, tag counter and completion re-arm
  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    done_d      = 1'b0;
    ack_d       = 1'b0;
    ack_tag_d   = ack_tag_q;
    tag_d       = tag_q;
    // The receive engine holds its request a cycle past done; only a low level re-arms.
    cpl_armed_d = cpl_armed_q | ~req_compl_wd_i;
    cap_cpl     = 1'b0;
    cap_mrd     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tvalid_d = 1'b0;
        // Completion has strict priority over DMA reads.
        if (req_compl_wd_i && cpl_armed_q) begin
          state_d = S_CPL_HDR;
          cap_cpl = 1'b1;
        end else if (dma_rd_req_i) begin
          state_d = S_MRD_HDR;
          cap_mrd = 1'b1;
        end
      end

      S_CPL_HDR: begin
        if (!tvalid_q) begin
          // First cycle after IDLE: present beat 0 from the captured fields.
          tdata_d  = cpl_beat0;
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
        end else if (beat_fire) begin
          tdata_d = cpl_beat1;
          tkeep_d = 8'hFF;
          tlast_d = 1'b1;
          state_d = S_CPL_DATA;
        end
      end

      S_CPL_DATA: begin
        if (beat_fire) begin
          tdata_d     = '0;
          tkeep_d     = '0;
          tlast_d     = 1'b0;
          tvalid_d    = 1'b0;
          done_d      = 1'b1;
          cpl_armed_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_MRD_HDR: begin
        if (!tvalid_q) begin
          tdata_d  = mrd_beat0;
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
        end else if (beat_fire) begin
          tdata_d = mrd_beat1;
          tkeep_d = 8'h0F;
          tlast_d = 1'b1;
          state_d = S_MRD_ADDR;
        end
      end

      S_MRD_ADDR: begin
        if (beat_fire) begin
          tdata_d   = '0;
          tkeep_d   = '0;
          tlast_d   = 1'b0;
          tvalid_d  = 1'b0;
          ack_d     = 1'b1;
          ack_tag_d = tag_q;
          tag_d     = (tag_q == TAG_MAX) ? 8'd0 : tag_q + 8'd1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State, output and counter registers; reset drops tvalid immediately
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tag_q       <= 8'd0;
      cpl_armed_q <= 1'b1;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      ack_tag_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      cpl_armed_q <= cpl_armed_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      ack_tag_q   <= ack_tag_d;
    end
  end

  // Request field capture on the IDLE exit edge
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cid_q      <= 16'd0;
      tc_q       <= 3'd0;
      td_q       <= 1'b0;
      ep_q       <= 1'b0;
      attr_q     <= 2'd0;
      rid_q      <= 16'd0;
      rtag_q     <= 8'd0;
      raddr_q    <= 7'd0;
      rdata_q    <= 32'd0;
      mrd_addr_q <= 30'd0;
      mrd_len_q  <= 10'd0;
    end else begin
      if (cap_cpl || cap_mrd) begin
        cid_q <= completer_id_i;
      end
      if (cap_cpl) begin
        tc_q    <= req_tc_i;
        td_q    <= req_td_i;
        ep_q    <= req_ep_i;
        attr_q  <= req_attr_i;
        rid_q   <= req_rid_i;
        rtag_q  <= req_tag_i;
        raddr_q <= req_addr_i;
        rdata_q <= tx_reg_data_i;
      end
      if (cap_mrd) begin
        mrd_addr_q <= dma_rd_addr_i[31:2];
        mrd_len_q  <= dma_rd_len_i;
      end
    end
  end

  assign s_axis_tx_tdata  = tdata_q;
  assign s_axis_tx_tkeep  = tkeep_q;
  assign s_axis_tx_tlast  = tlast_q;
  assign s_axis_tx_tvalid = tvalid_q;
  assign compl_done_o     = done_q;
  assign dma_rd_ack_o     = ack_q;
  assign dma_rd_tag_o     = ack_tag_q;

endmodule
